// File: rtl/tetris_pkg.sv
// Shared constants, shape table and enums for the falling-piece sequencer.
// SHAPES holds seven 4x4 footprints; bit idx of a piece is 4*py+px in its unrotated box.
package tetris_pkg;

    localparam int WIDTH  = 10;
    localparam int HEIGHT = 20;

    // Piece order (low to high): I, J, L, O, S, T, Z.
    localparam logic [111:0] SHAPES = {
        16'h0C60,   // 6 Z
        16'h0E40,   // 5 T
        16'h06C0,   // 4 S
        16'h0660,   // 3 O
        16'h0E80,   // 2 L
        16'h0E20,   // 1 J
        16'h0F00    // 0 I
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RESOLVE,
        ST_LOCK,
        ST_SPAWN,
        ST_OVER
    } state_t;

    typedef enum logic [2:0] {
        K_LEFT,
        K_RIGHT,
        K_ROTATE,
        K_DOWN,
        K_TICK,
        K_SPAWN
    } kind_t;

    function automatic logic [3:0] rot_index(input logic [1:0] rot,
                                             input logic [1:0] px,
                                             input logic [1:0] py);
        int x;
        int y;
        int r;
        x = {30'b0, px};
        y = {30'b0, py};
        case (rot)
            2'd0:    r = 4 * y + x;
            2'd1:    r = 12 + y - 4 * x;
            2'd2:    r = 15 - 4 * y - x;
            default: r = 3 - y + 4 * x;
        endcase
        return 4'(r);
    endfunction

endpackage

// File: rtl/cell_lookup.sv
// Combinational footprint lookup: is cell (px,py) of a piece at a rotation occupied.
module cell_lookup
    import tetris_pkg::*;
(
    input  logic [2:0] piece,
    input  logic [1:0] rot,
    input  logic [1:0] px,
    input  logic [1:0] py,
    output logic       occupied
);

    logic [6:0] bit_idx;

    assign bit_idx  = {piece, rot_index(rot, px, py)};
    // Piece code 7 has no shape; treat it as empty rather than reading past the table.
    assign occupied = (piece != 3'd7) && SHAPES[bit_idx];

endmodule

// File: rtl/piece_ctrl.sv
// Falling-piece sequencer: arbitrates moves and gravity, validates each candidate
// with a 16-cycle footprint scan, locks failed drops into the board and spawns.
module piece_ctrl
#(
    parameter int WIDTH   = 10,
    parameter int HEIGHT  = 20,
    parameter int SPAWN_X = 3
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_left,
    input  logic                      req_right,
    input  logic                      req_rotate,
    input  logic                      req_down,
    input  logic                      tick,
    input  logic [WIDTH*HEIGHT-1:0]   board,
    input  logic                      board_busy,
    input  logic [2:0]                next_piece,
    output logic signed [31:0]        cur_x,
    output logic signed [31:0]        cur_y,
    output logic [31:0]               cur_rot,
    output logic [31:0]               cur_piece,
    output logic                      busy,
    output logic                      lock_we,
    output logic [7:0]                lock_idx,
    output logic                      lock_done,
    output logic                      game_over
);
    import tetris_pkg::*;

    state_t             state, state_n;
    kind_t              kind, grant_kind;
    logic [3:0]         c;
    logic [4:0]         pend, grant, pulses;
    logic signed [31:0] cx, cy, cand_x, cand_y;
    logic [1:0]         crot, cand_rot;
    logic [2:0]         cpiece, cand_piece;
    logic               hit, lock_done_q, game_over_q;

    // Footprint scan: LOCK walks the committed piece, CHECK walks the candidate.
    logic               in_lock;
    logic signed [31:0] sel_x, sel_y, gx, gy;
    logic [1:0]         sel_rot;
    logic [2:0]         sel_piece;
    int                 px_i, py_i;
    logic               occ, inb, cell_hit;
    logic [7:0]         lin;

    assign in_lock   = (state == ST_LOCK);
    assign sel_x     = in_lock ? cx     : cand_x;
    assign sel_y     = in_lock ? cy     : cand_y;
    assign sel_rot   = in_lock ? crot   : cand_rot;
    assign sel_piece = in_lock ? cpiece : cand_piece;

    cell_lookup u_lookup (
        .piece    (sel_piece),
        .rot      (sel_rot),
        .px       (c[1:0]),
        .py       (c[3:2]),
        .occupied (occ)
    );

    always_comb begin
        px_i     = {30'b0, c[1:0]};
        py_i     = {30'b0, c[3:2]};
        gx       = sel_x + px_i;
        gy       = sel_y + py_i;
        inb      = (gx >= 0) && (gx < WIDTH) && (gy >= 0) && (gy < HEIGHT);
        lin      = inb ? 8'(HEIGHT * gx + gy) : 8'd0;
        cell_hit = occ && (!inb || board[lin]);
    end

    // Pending bits ordered by grant priority: tick, down, rotate, left, right.
    assign pulses = {tick, req_down, req_rotate, req_left, req_right};

    always_comb begin
        grant      = '0;
        grant_kind = K_TICK;
        if (state == ST_IDLE) begin
            if (pend[4]) begin
                grant = 5'b10000; grant_kind = K_TICK;
            end else if (pend[3]) begin
                grant = 5'b01000; grant_kind = K_DOWN;
            end else if (pend[2]) begin
                grant = 5'b00100; grant_kind = K_ROTATE;
            end else if (pend[1]) begin
                grant = 5'b00010; grant_kind = K_LEFT;
            end else if (pend[0]) begin
                grant = 5'b00001; grant_kind = K_RIGHT;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:    if (|grant) state_n = ST_CHECK;
            ST_CHECK:   if (c == 4'd15) state_n = ST_RESOLVE;
            ST_RESOLVE: begin
                if (!hit) begin
                    state_n = ST_IDLE;
                end else begin
                    unique case (kind)
                        K_LEFT, K_RIGHT, K_ROTATE: state_n = ST_IDLE;
                        K_DOWN, K_TICK:            state_n = ST_LOCK;
                        default:                   state_n = ST_OVER;
                    endcase
                end
            end
            ST_LOCK:    if (c == 4'd15) state_n = ST_SPAWN;
            ST_SPAWN:   if (!board_busy) state_n = ST_CHECK;
            ST_OVER:    state_n = ST_OVER;
            default:    state_n = ST_SPAWN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_SPAWN;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= '0;
            kind        <= K_SPAWN;
            c           <= '0;
            hit         <= 1'b0;
            cx          <= 32'(SPAWN_X);
            cy          <= '0;
            crot        <= '0;
            cpiece      <= '0;
            cand_x      <= 32'(SPAWN_X);
            cand_y      <= '0;
            cand_rot    <= '0;
            cand_piece  <= '0;
            lock_done_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            // A pulse coincident with its own grant re-arms the bit.
            pend        <= (state == ST_OVER) ? 5'b0 : ((pend & ~grant) | pulses);
            lock_done_q <= in_lock && (c == 4'd15);
            case (state)
                ST_IDLE: if (|grant) begin
                    kind       <= grant_kind;
                    c          <= '0;
                    hit        <= 1'b0;
                    cand_x     <= cx;
                    cand_y     <= cy;
                    cand_rot   <= crot;
                    cand_piece <= cpiece;
                    case (grant_kind)
                        K_LEFT:   cand_x   <= cx - 32'sd1;
                        K_RIGHT:  cand_x   <= cx + 32'sd1;
                        K_ROTATE: cand_rot <= crot + 2'd1;
                        default:  cand_y   <= cy + 32'sd1;
                    endcase
                end
                ST_CHECK: begin
                    hit <= hit | cell_hit;
                    c   <= c + 4'd1;
                end
                ST_RESOLVE: begin
                    c <= '0;
                    if (!hit) begin
                        cx     <= cand_x;
                        cy     <= cand_y;
                        crot   <= cand_rot;
                        cpiece <= cand_piece;
                    end else if (kind == K_SPAWN) begin
                        game_over_q <= 1'b1;
                    end
                end
                ST_LOCK: c <= c + 4'd1;
                ST_SPAWN: if (!board_busy) begin
                    kind       <= K_SPAWN;
                    c          <= '0;
                    hit        <= 1'b0;
                    cand_x     <= 32'(SPAWN_X);
                    cand_y     <= '0;
                    cand_rot   <= '0;
                    cand_piece <= (next_piece == 3'd7) ? 3'd0 : next_piece;
                end
                default: ;
            endcase
        end
    end

    assign cur_x     = cx;
    assign cur_y     = cy;
    assign cur_rot   = {30'b0, crot};
    assign cur_piece = {29'b0, cpiece};
    assign busy      = (state != ST_IDLE);
    assign lock_we   = in_lock && occ && inb;
    assign lock_idx  = lock_we ? lin : 8'd0;
    assign lock_done = lock_done_q;
    assign game_over = game_over_q;

endmodule
